vend_machine_param: RTL

VEND_MACHINE_PARAM -- requirements
Module: vend_machine_param

---
 rtl/vend_pkg.sv | 28 ++
 rtl/vend_stock_bank.sv | 46 ++++
 rtl/vend_machine_param.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, coin codes and price lookup for the vending machine
// Purpose: state encoding, legal coin codes and the packed price-table accessor.
// Ports: none (package).
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_COLLECT,
    ST_VEND,
    ST_REFUND
  } vend_state_t;

  localparam logic [1:0] COIN_1 = 2'd1;
  localparam logic [1:0] COIN_2 = 2'd2;

  // Widest price table supported (16 items of up to 16-bit prices).
  localparam int PRICE_TBL_W = 256;

  // Returns the w-bit price of item idx from a table packed item 0 in the LSBs.
  function automatic logic [31:0] price_at(input logic [PRICE_TBL_W-1:0] tbl,
                                           input int idx, input int w);
    logic [PRICE_TBL_W-1:0] sh;
    sh = tbl >> (idx * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// rtl/vend_stock_bank.sv - per-item stock counters with restock/decrement arbitration
// Purpose: holds one saturating stock counter per item and flags empty items.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   restock_valid, restock_idx  refill item to full scale
//   dec_valid, dec_idx          take one unit of an item
//   sold_out                    bit i high when item i has no stock
module vend_stock_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int IDX_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restock_valid,
  input  logic [IDX_W-1:0]     restock_idx,
  input  logic                 dec_valid,
  input  logic [IDX_W-1:0]     dec_idx,
  output logic [NUM_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

  // An out-of-range restock index matches no counter and is thereby ignored.
  // Restock takes priority over a same-cycle decrement of the same item.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (restock_valid && restock_idx == IDX_W'(i)) begin
          stock_q[i] <= '1;
        end else if (dec_valid && dec_idx == IDX_W'(i) && stock_q[i] != '0) begin
          stock_q[i] <= stock_q[i] - STOCK_W'(1);
        end
      end
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

endmodule

// File: rtl/vend_machine_param.sv
// rtl/vend_machine_param.sv - parameterised vending machine controller
// Purpose: item selection, coin collection, vend with change, cancel/timeout refund.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   sel_valid, sel_idx           item selection strobe and index
//   coin_valid, coin_val         coin strobe and value (1 or 2 legal)
//   cancel                       cancel request
//   restock_valid, restock_idx   refill an item to full scale
//   vend, vend_idx, change       release pulse, released item, change
//   refund_valid, refund         refund pulse and returned credit
//   err                          error pulse
//   busy                         high outside IDLE
//   sold_out                     per-item empty flags
module vend_machine_param #(
  parameter int                            NUM_ITEMS   = 4,
  parameter int                            CREDIT_W    = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES      = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int                            STOCK_W     = 4,
  parameter int                            STOCK_INIT  = 8,
  parameter int                            TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_idx,
  input  logic                         coin_valid,
  input  logic [1:0]                   coin_val,
  input  logic                         cancel,
  input  logic                         restock_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] restock_idx,
  output logic                         vend,
  output logic [$clog2(NUM_ITEMS)-1:0] vend_idx,
  output logic [CREDIT_W-1:0]          change,
  output logic [CREDIT_W-1:0]          refund,
  output logic                         refund_valid,
  output logic                         err,
  output logic                         busy,
  output logic [NUM_ITEMS-1:0]         sold_out
);
  import vend_pkg::*;

  localparam int                IDX_W    = $clog2(NUM_ITEMS);
  localparam int                TMR_W    = $clog2(TIMEOUT_CYC + 1);
  // Loading TIMEOUT_CYC-1 and expiring at 0 gives exactly TIMEOUT_CYC idle COLLECT cycles.
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  vend_state_t         state_q, state_n;
  logic [IDX_W-1:0]    sel_q, sel_n;
  logic [CREDIT_W-1:0] credit_q, credit_n, credit_sum;
  logic [TMR_W-1:0]    tmr_q, tmr_n;
  logic [CREDIT_W-1:0] price;
  logic                idx_ok, coin_ok;

  logic                vend_n, refund_valid_n, err_n;
  logic [IDX_W-1:0]    vend_idx_n;
  logic [CREDIT_W-1:0] change_n, refund_n;

  assign price   = CREDIT_W'(price_at(PRICE_TBL_W'(PRICES), int'(sel_q), CREDIT_W));
  assign idx_ok  = ({1'b0, sel_q} < (IDX_W + 1)'(NUM_ITEMS));
  assign coin_ok = coin_valid && (coin_val == COIN_1 || coin_val == COIN_2);
  assign busy    = (state_q != ST_IDLE);

  vend_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT),
    .IDX_W      (IDX_W)
  ) u_stock (
    .clk           (clk),
    .rst           (rst),
    .restock_valid (restock_valid),
    .restock_idx   (restock_idx),
    .dec_valid     (state_q == ST_VEND),
    .dec_idx       (sel_q),
    .sold_out      (sold_out)
  );

  always_comb begin
    state_n        = state_q;
    sel_n          = sel_q;
    credit_n       = credit_q;
    credit_sum     = credit_q;
    tmr_n          = tmr_q;
    vend_n         = 1'b0;
    vend_idx_n     = '0;
    change_n       = '0;
    refund_valid_n = 1'b0;
    refund_n       = '0;
    err_n          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (coin_valid) err_n = 1'b1;
        if (sel_valid) begin
          sel_n    = sel_idx;
          credit_n = '0;
          state_n  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (idx_ok && !sold_out[sel_q]) begin
          state_n = ST_COLLECT;
          tmr_n   = TMR_LOAD;
        end else begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        // Once paid, coins and cancel are no longer looked at; this keeps
        // credit at most price+1 (price-1 plus a 2-coin).
        if (credit_q >= price) begin
          state_n    = ST_VEND;
          vend_n     = 1'b1;
          vend_idx_n = sel_q;
          change_n   = credit_q - price;
        end else begin
          if (coin_ok) begin
            credit_sum = credit_q + CREDIT_W'(coin_val);
            tmr_n      = TMR_LOAD;
          end else if (coin_valid) begin
            err_n = 1'b1;
          end
          credit_n = credit_sum;
          // A coin arriving with cancel is already folded into credit_sum.
          if (cancel || (!coin_ok && tmr_q == '0)) begin
            state_n        = ST_REFUND;
            refund_valid_n = 1'b1;
            refund_n       = credit_sum;
          end else if (!coin_ok) begin
            tmr_n = tmr_q - TMR_W'(1);
          end
        end
      end
      ST_VEND: begin
        credit_n = '0;
        state_n  = ST_IDLE;
      end
      ST_REFUND: begin
        credit_n = '0;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      credit_q     <= '0;
      tmr_q        <= '0;
      vend         <= 1'b0;
      vend_idx     <= '0;
      change       <= '0;
      refund_valid <= 1'b0;
      refund       <= '0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_n;
      sel_q        <= sel_n;
      credit_q     <= credit_n;
      tmr_q        <= tmr_n;
      vend         <= vend_n;
      vend_idx     <= vend_idx_n;
      change       <= change_n;
      refund_valid <= refund_valid_n;
      refund       <= refund_n;
      err          <= err_n;
    end
  end

endmodule
